// File: rtl/i2s_stream_ctrl_if.sv
// i2s_stream_ctrl_if: configuration, source and tx_i2s FIFO signals of the I2S stream controller.
// The slave modport is the controller; the master modport is its environment (config requester,
// audio source and tx_i2s). Bit depth codes: 0=16-bit, 1=24-bit, 2=32-bit, 3=DOP.
interface i2s_stream_ctrl_if;
  logic       cfg_valid_i;
  logic [2:0] cfg_sample_rate_i;
  logic [1:0] cfg_bit_depth_i;
  logic       cfg_ready_o;
  logic       src_valid_i;
  logic [7:0] src_data_i;
  logic       src_last_i;
  logic       src_ready_o;
  logic       fifo_wr_en_o;
  logic [7:0] fifo_wr_data_o;
  logic       fifo_afull_i;
  logic       streaming_i;

  modport slave (
    input  cfg_valid_i, cfg_sample_rate_i, cfg_bit_depth_i,
    output cfg_ready_o,
    input  src_valid_i, src_data_i, src_last_i,
    output src_ready_o,
    output fifo_wr_en_o, fifo_wr_data_o,
    input  fifo_afull_i, streaming_i
  );

  modport master (
    output cfg_valid_i, cfg_sample_rate_i, cfg_bit_depth_i,
    input  cfg_ready_o,
    output src_valid_i, src_data_i, src_last_i,
    input  src_ready_o,
    input  fifo_wr_en_o, fifo_wr_data_o,
    output fifo_afull_i, streaming_i
  );
endinterface

// File: rtl/i2s_stream_ctrl.sv
// i2s_stream_ctrl: owns the I2S stream configuration and moves source bytes into the tx_i2s
// output FIFO, padding every stream out to a whole stereo frame.
//
//   state  | meaning
//   IDLE   | path quiet; accepts config or a new stream
//   SETTLE | clock generator relocking after a config change
//   STREAM | forwarding source bytes to the FIFO
//   PAD    | writing zero bytes to finish the last frame
//   DRAIN  | waiting for tx_i2s to stop streaming (bounded)
module i2s_stream_ctrl #(
  parameter logic [2:0] DEFAULT_RATE  = 3'd0,
  parameter logic [1:0] DEFAULT_DEPTH = 2'd0,
  parameter int         SETTLE_CYCLES = 256,
  parameter int         DRAIN_TIMEOUT = 4096
) (
  input  logic                    byte_clk_i,
  input  logic                    reset_i,
  i2s_stream_ctrl_if.slave        bus,
  output logic [2:0]              sample_rate_o,
  output logic [1:0]              bit_depth_o,
  output logic                    busy_o,
  output logic                    underrun_o,
  output logic [7:0]              underrun_cnt_o
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_PAD    = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;

  localparam int TMR_MAX = (SETTLE_CYCLES > DRAIN_TIMEOUT) ? SETTLE_CYCLES : DRAIN_TIMEOUT;
  localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  logic [2:0]       state;
  logic [TMR_W-1:0] tmr;
  logic [2:0]       fcnt;
  logic [2:0]       fb_last;
  logic             wr_en_q;
  logic [7:0]       wr_data_q;
  logic             wrote_q;
  logic             streaming_q;
  logic             cfg_hs;
  logic             src_hs;
  logic             frame_end;
  logic             underrun_det;

  // Last byte index of a stereo frame for a given bit depth (24-bit and DOP share 6 bytes).
  function automatic logic [2:0] frame_last(input logic [1:0] depth);
    case (depth)
      2'd0:    frame_last = 3'd3;
      2'd2:    frame_last = 3'd7;
      default: frame_last = 3'd5;
    endcase
  endfunction

  assign bus.cfg_ready_o    = (state == ST_IDLE) && !bus.streaming_i;
  assign bus.src_ready_o    = (state == ST_STREAM) && !bus.fifo_afull_i;
  assign bus.fifo_wr_en_o   = wr_en_q;
  assign bus.fifo_wr_data_o = wr_data_q;
  assign busy_o             = (state != ST_IDLE);

  assign cfg_hs       = bus.cfg_valid_i && bus.cfg_ready_o;
  assign src_hs       = bus.src_valid_i && bus.src_ready_o;
  assign frame_end    = (fcnt == fb_last);
  assign underrun_det = (state == ST_STREAM) && wrote_q && streaming_q && !bus.streaming_i;

  // Sequencer: state, shared down-counter, frame byte counter and registered FIFO write port.
  always_ff @(posedge byte_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= ST_IDLE;
      tmr           <= '0;
      fcnt          <= 3'd0;
      fb_last       <= 3'd3;
      wr_en_q       <= 1'b0;
      wr_data_q     <= 8'h00;
      wrote_q       <= 1'b0;
      sample_rate_o <= DEFAULT_RATE;
      bit_depth_o   <= DEFAULT_DEPTH;
    end else begin
      wr_en_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_hs) begin
            sample_rate_o <= bus.cfg_sample_rate_i;
            bit_depth_o   <= bus.cfg_bit_depth_i;
            tmr           <= TMR_W'(SETTLE_CYCLES - 1);
            state         <= ST_SETTLE;
          end else if (bus.src_valid_i && !bus.streaming_i) begin
            fcnt    <= 3'd0;
            fb_last <= frame_last(bit_depth_o);
            wrote_q <= 1'b0;
            state   <= ST_STREAM;
          end
        end
        ST_SETTLE: begin
          if (tmr == '0) state <= ST_IDLE;
          else           tmr   <= tmr - 1'b1;
        end
        ST_STREAM: begin
          if (src_hs) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= bus.src_data_i;
            wrote_q   <= 1'b1;
            fcnt      <= frame_end ? 3'd0 : fcnt + 3'd1;
            if (bus.src_last_i) begin
              if (frame_end) begin
                tmr   <= TMR_W'(DRAIN_TIMEOUT - 1);
                state <= ST_DRAIN;
              end else begin
                state <= ST_PAD;
              end
            end
          end
        end
        ST_PAD: begin
          if (!bus.fifo_afull_i) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= 8'h00;
            if (frame_end) begin
              fcnt  <= 3'd0;
              tmr   <= TMR_W'(DRAIN_TIMEOUT - 1);
              state <= ST_DRAIN;
            end else begin
              fcnt <= fcnt + 3'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (!bus.streaming_i || tmr == '0) state <= ST_IDLE;
          else                               tmr   <= tmr - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Underrun detection: falling streaming_i while a stream is mid-flight; count saturates at 255.
  always_ff @(posedge byte_clk_i or posedge reset_i) begin
    if (reset_i) begin
      streaming_q    <= 1'b0;
      underrun_o     <= 1'b0;
      underrun_cnt_o <= 8'h00;
    end else begin
      streaming_q <= bus.streaming_i;
      underrun_o  <= underrun_det;
      if (underrun_det && underrun_cnt_o != 8'hFF)
        underrun_cnt_o <= underrun_cnt_o + 8'd1;
    end
  end

endmodule
